booth_mul_sched: RTL



---
 rtl/booth_mul_pkg.sv | 25 ++
 rtl/booth_mul_sched_rr_arbiter.sv | 37 +++
 rtl/booth_mul_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/booth_mul_pkg.sv
// Shared definitions for the Booth multiplier scheduler.
//   state_e      : scheduler FSM state encoding (2 bits)
//   OP_W_DEF     : default signed operand width
//   PROD_W_DEF   : default product width (2*OP_W+1)
//   gnt_width()  : index width for a requester count (never below 1)
package booth_mul_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int OP_W_DEF    = 4;
    localparam int PROD_W_DEF  = 2 * OP_W_DEF + 1;

    function automatic int gnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GNT_W = gnt_width(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   gnt    : one-hot grant (zero when nothing requests)
//   gnt_id : index of the granted requester
//   any    : at least one request present
module rr_arbiter
    import booth_mul_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int GW = gnt_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] gnt_id,
    output logic          any
);

    // Walk from ptr upward, wrapping; the first requester seen wins.
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one multi-cycle signed multiplier among NUM_REQ requesters.
// One operation at a time: grant (IDLE) -> start pulse (ISSUE) ->
// wait for a fresh result edge or watchdog abort (WAIT) -> return (RESP).
//   clk, resetn              : clock, async active-low reset
//   req_valid/req_ready      : per-requester request handshake
//   req_m/req_a              : packed operands, requester i at [i*OP_W +: OP_W]
//   rsp_valid/rsp_ready      : per-requester response handshake
//   rsp_product/rsp_err      : shared response bus; err marks a timeout abort
//   mul_start/mul_m/mul_a    : multiplier launch and latched operands
//   mul_valid/mul_product    : multiplier result
//   busy                     : scheduler not idle
module booth_mul_sched
    import booth_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_m,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [PROD_W-1:0]       rsp_product,
    output logic                    rsp_err,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_m,
    output logic [OP_W-1:0]         mul_a,
    input  logic                    mul_valid,
    input  logic [PROD_W-1:0]       mul_product,
    output logic                    busy
);

    localparam int GW = gnt_width(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       gnt_id_q, gnt_id_d;
    logic [OP_W-1:0]     m_q, m_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                err_q, err_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                mul_valid_q, mul_valid_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [GW-1:0]       arb_id;
    logic                arb_any;
    logic                mul_edge;
    logic                timed_out;
    logic                rsp_hs;

    rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // Only a rising edge counts, so a level left high by the previous
    // operation cannot complete the next one.
    assign mul_edge    = mul_valid & ~mul_valid_q;
    assign timed_out   = (timer_q == TW'(TIMEOUT - 1));
    assign rsp_hs      = (state_q == S_RESP) && rsp_ready[gnt_id_q];
    assign mul_valid_d = mul_valid;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            m_q         <= '0;
            a_q         <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            mul_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            m_q         <= m_d;
            a_q         <= a_d;
            prod_q      <= prod_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            mul_valid_q <= mul_valid_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (mul_edge || timed_out) state_d = S_RESP;
            S_RESP:  if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        m_d      = m_q;
        a_d      = a_q;
        prod_d   = prod_q;
        err_d    = err_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_id_d = arb_id;
                    m_d      = req_m[arb_id*OP_W +: OP_W];
                    a_d      = req_a[arb_id*OP_W +: OP_W];
                end
            end
            S_ISSUE: timer_d = '0;
            S_WAIT: begin
                // A result edge beats a coincident timeout.
                if (mul_edge) begin
                    prod_d = mul_product;
                    err_d  = 1'b0;
                end else if (timed_out) begin
                    prod_d = '0;
                    err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_hs)
                    rr_ptr_d = (gnt_id_q == GW'(NUM_REQ - 1)) ? '0 : GW'(gnt_id_q + 1'b1);
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready   = (state_q == S_IDLE) ? arb_gnt : '0;
        rsp_valid   = '0;
        if (state_q == S_RESP) rsp_valid[gnt_id_q] = 1'b1;
        mul_start   = (state_q == S_ISSUE);
        mul_m       = m_q;
        mul_a       = a_q;
        rsp_product = prod_q;
        rsp_err     = err_q;
        busy        = (state_q != S_IDLE);
    end

endmodule
